// File: rtl/sdc_pkg.sv
// Shared FSM state encoding and width helper for the serial run-of-ones sequencer.
package sdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } state_e;

  // Never returns less than 1, so a derived counter width is always legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ones_run_detector.sv
// Overlapping run-of-ones Mealy detector: detect is combinational from the current bit and run state.
// The run state only moves on enabled bits and saturates at RUN_LEN-1.
module ones_run_detector
  import sdc_pkg::*;
#(
  parameter int RUN_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic detect
);

  localparam int RUN_W = clog2(RUN_LEN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN - 1);

  logic [RUN_W-1:0] run_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q <= '0;
    end else if (clr) begin
      run_q <= '0;
    end else if (en) begin
      if (!bit_in) begin
        run_q <= '0;
      end else if (run_q != RUN_MAX) begin
        run_q <= run_q + 1'b1;
      end
    end
  end

  assign detect = en & bit_in & (run_q == RUN_MAX);

endmodule

// File: rtl/serial_detect_ctrl.sv
// Word-to-serial sequencer feeding ones_run_detector; MSB on bit_out the cycle after acceptance, one bubble per word.
// in_ready only in WAIT_WORD (producer holds otherwise). SDC_SATURATE_EN selects saturating det_count with sticky ovf.
module serial_detect_ctrl
  import sdc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 8,
  parameter int RUN_LEN = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             detect,
  output logic [CNT_W-1:0] det_count,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int BCNT_W = clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   sreg_q;
  logic [BCNT_W-1:0]  bit_cnt_q;
  logic               last_q;
  logic               in_ready_q;
  logic               bit_valid_q;
  logic               busy_q;
  logic               done_q;
  logic [CNT_W-1:0]   det_count_q;
  logic [CNT_W-1:0]   det_count_d;
  logic               session_clr;
  logic               det;

  assign session_clr = start && (state_q == IDLE);

  // Outputs are registered alongside the state transition that implies them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      bit_cnt_q   <= '0;
      last_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      bit_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= WAIT_WORD;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        WAIT_WORD: begin
          if (in_valid) begin
            sreg_q      <= in_data;
            last_q      <= in_last;
            bit_cnt_q   <= BCNT_W'(WIDTH - 1);
            state_q     <= SHIFT;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b1;
          end
        end
        SHIFT: begin
          sreg_q    <= sreg_q << 1;
          bit_cnt_q <= bit_cnt_q - 1'b1;
          if (bit_cnt_q == '0) begin
            bit_valid_q <= 1'b0;
            if (last_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q    <= WAIT_WORD;
              in_ready_q <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          bit_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  ones_run_detector #(
    .RUN_LEN (RUN_LEN)
  ) u_det (
    .clk    (clk),
    .reset  (reset),
    .clr    (session_clr),
    .en     (bit_valid_q),
    .bit_in (sreg_q[WIDTH-1]),
    .detect (det)
  );

`ifdef SDC_SATURATE_EN
  logic ovf_q;
  logic ovf_d;

  always_comb begin
    det_count_d = det_count_q;
    ovf_d       = ovf_q;
    if (session_clr) begin
      det_count_d = '0;
      ovf_d       = 1'b0;
    end else if (det) begin
      if (&det_count_q) begin
        ovf_d = 1'b1;
      end else begin
        det_count_d = det_count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  always_comb begin
    det_count_d = det_count_q;
    if (session_clr) begin
      det_count_d = '0;
    end else if (det) begin
      det_count_d = det_count_q + 1'b1;
    end
  end

  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      det_count_q <= '0;
    end else begin
      det_count_q <= det_count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bit_valid = bit_valid_q;
  assign bit_out   = bit_valid_q & sreg_q[WIDTH-1];
  assign detect    = det;
  assign det_count = det_count_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_detect_ctrl.sv
// Scoreboard bench for serial_detect_ctrl with a narrow counter so wrap/saturation is reached often.
module tb_serial_detect_ctrl;

  localparam int WIDTH   = 8;
  localparam int CNT_W   = 3;
  localparam int RUN_LEN = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             bit_out;
  logic             bit_valid;
  logic             detect;
  logic [CNT_W-1:0] det_count;
  logic             busy;
  logic             done;
  logic             ovf;

  serial_detect_ctrl #(
    .WIDTH   (WIDTH),
    .CNT_W   (CNT_W),
    .RUN_LEN (RUN_LEN)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .detect    (detect),
    .det_count (det_count),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic b;
    logic d;
  } bit_exp_t;

  typedef struct {
    int   cnt;
    logic o;
  } done_exp_t;

  bit_exp_t         exp_bits[$];
  done_exp_t        exp_done[$];
  logic [WIDTH-1:0] words[$];
  int               gaps[$];
  int               checks = 0;
  int               errors = 0;
  int               last_cnt = 0;
  logic             last_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a bit detects when it and the RUN_LEN-1 session bits before it are all ones.
  task automatic plan_session();
    logic hist[$];
    int   n_det;
    n_det = 0;
    foreach (words[i]) begin
      for (int b = WIDTH - 1; b >= 0; b--) begin
        bit_exp_t e;
        logic     w;
        w = words[i][b];
        hist.push_back(w);
        e.b = w;
        e.d = 1'b0;
        if (hist.size() >= RUN_LEN) begin
          e.d = 1'b1;
          for (int k = 0; k < RUN_LEN; k++) begin
            if (!hist[hist.size() - 1 - k]) e.d = 1'b0;
          end
        end
        if (e.d) n_det++;
        exp_bits.push_back(e);
      end
    end
`ifdef SDC_SATURATE_EN
    last_cnt = (n_det > CNT_MAX) ? CNT_MAX : n_det;
    last_ovf = (n_det > CNT_MAX);
`else
    last_cnt = n_det % (CNT_MAX + 1);
    last_ovf = 1'b0;
`endif
    exp_done.push_back('{cnt: last_cnt, o: last_ovf});
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("ready_timeout", in_ready, 1);
  endtask

  // Entered and left at posedge+#1 with the DUT idle.
  task automatic run_session(input bit poke_start);
    int t;
    plan_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      wait_ready();
      for (int g = 0; g < gaps[i]; g++) begin
        @(posedge clk); #1;
        chk("gap_in_ready", in_ready, 1);
        chk("gap_bit_valid", bit_valid, 0);
      end
      in_valid = 1'b1;
      in_data  = words[i];
      in_last  = (i == words.size() - 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      chk("msb_latency", bit_valid, 1);
      chk("ready_drop", in_ready, 0);
      if (poke_start && i == 0) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    t = 0;
    while (busy && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("done_timeout", busy, 0);
    @(posedge clk); #1;
    chk("held_count", det_count, last_cnt);
    chk("held_ovf", ovf, last_ovf);
  endtask

  // Monitor: pops expectations whenever the DUT presents a bit or a done pulse.
  initial begin
    logic prev_bv;
    logic prev_done;
    prev_bv   = 1'b0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bit_valid) begin
        if (exp_bits.size() == 0) begin
          chk("unexpected_bit", bit_valid, 0);
        end else begin
          bit_exp_t e;
          e = exp_bits.pop_front();
          chk("bit_out", bit_out, e.b);
          chk("detect", detect, e.d);
        end
      end else if (bit_out || detect) begin
        chk("idle_bit_out", bit_out, 0);
        chk("idle_detect", detect, 0);
      end
      if (done) begin
        chk("done_after_last_bit", prev_bv, 1);
        chk("done_busy", busy, 1);
        if (exp_done.size() == 0) begin
          chk("unexpected_done", done, 0);
        end else begin
          done_exp_t d;
          d = exp_done.pop_front();
          chk("det_count", det_count, d.cnt);
          chk("ovf", ovf, d.o);
        end
      end
      if (prev_done) chk("busy_after_done", busy, 0);
      prev_bv   = bit_valid;
      prev_done = done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_count", det_count, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ovf", ovf, 0);

    words = '{8'hFF};       gaps = '{0};    run_session(0);
    chk("ff_count", det_count, 6);
    words = '{8'h03, 8'h80}; gaps = '{0, 0}; run_session(0);
    chk("span_count", det_count, 1);
    words = '{8'hB6};       gaps = '{0};    run_session(0);
    chk("b6_count", det_count, 0);
    words = '{8'h03, 8'h80}; gaps = '{0, 5}; run_session(0);
    chk("held_run_count", det_count, 1);
    words = '{8'hFF, 8'h01}; gaps = '{0, 1}; run_session(1);

    // Abort a session mid-shift with reset.
    words = '{8'hFF}; gaps = '{0};
    plan_session();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_ready();
    in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_count", det_count, 0);
    chk("abort_detect", detect, 0);
    exp_bits.delete();
    exp_done.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_idle_ready", in_ready, 0);

    words = '{8'hFF, 8'hFF}; gaps = '{0, 0}; run_session(0);
`ifdef SDC_SATURATE_EN
    chk("sat_count", det_count, 7);
    chk("sat_ovf", ovf, 1);
`else
    chk("wrap_count", det_count, 6);
    chk("wrap_ovf", ovf, 0);
`endif

    for (int s = 0; s < 40; s++) begin
      int nw;
      nw = $urandom_range(1, 4);
      words.delete();
      gaps.delete();
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 2) == 0) words.push_back(WIDTH'($urandom));
        else words.push_back(WIDTH'($urandom | $urandom));
        gaps.push_back($urandom_range(0, 3));
      end
      run_session($urandom_range(0, 3) == 0);
    end

    repeat (5) @(posedge clk);
    #1;
    chk("bits_drained", exp_bits.size(), 0);
    chk("dones_drained", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
